wdt_reset_ctrl: RTL

Downstream consumer of the watchdog block's output in the CLOCK/WDT area. Turns a watchdog fault into a timed system reset pulse, then blanks further faults while the watchdog restarts. Counts trips and enters a latched lockout after too many trips inside a retry window. Exposes status to the SPI register map.

---
 rtl/wdt_reset_ctrl.sv | 183 ++++++++++++++++++
 1 files changed

// File: rtl/wdt_reset_ctrl.sv
// Watchdog-fault to system-reset controller with blanking, retry window and lockout.
// Optional macro RSTCTRL_TIMESTAMP_EN builds a free-running ms counter for last_trip_ms.
module wdt_reset_ctrl #(
  parameter logic [15:0] HOLD_TIME    = 16'd10,
  parameter logic [15:0] BLANK_TIME   = 16'd100,
  parameter logic [15:0] RETRY_WINDOW = 16'd1000,
  parameter logic [7:0]  MAX_RETRIES  = 8'd3
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_1kHz,
  input  logic        wdt_fault,
  input  logic        clear_status,
  output logic        sys_reset,
  output logic        fault_latched,
  output logic        lockout,
  output logic [7:0]  trip_count,
  output logic [1:0]  state,
  output logic [15:0] last_trip_ms
);

  typedef enum logic [1:0] {
    S_RUN    = 2'd0,
    S_ASSERT = 2'd1,
    S_BLANK  = 2'd2,
    S_LOCK   = 2'd3
  } state_t;

  localparam logic [15:0] HOLD_LAST  = (HOLD_TIME == 16'd0) ? 16'd0 : HOLD_TIME - 16'd1;
  localparam logic [15:0] BLANK_LAST = BLANK_TIME - 16'd1;
  localparam logic [15:0] WIN_LAST   = RETRY_WINDOW - 16'd1;

  logic   sync1_q, sync2_q, edge_q;
  logic   ms_tick;
  logic   trip;
  state_t state_q, state_d;
  logic   sys_reset_q, sys_reset_d;
  logic   lockout_q, lockout_d;
  logic   fault_latched_q, fault_latched_d;
  logic [7:0]  trip_count_q, trip_count_d, trip_base;
  logic [7:0]  retry_q, retry_d;
  logic [15:0] win_q, win_d;
  logic [15:0] hold_q, hold_d;
  logic [15:0] blank_q, blank_d;

  // Synchroniser and rising-edge detect of the 1 kHz reference
  always_ff @(posedge clk) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      edge_q  <= 1'b0;
    end else begin
      sync1_q <= clk_1kHz;
      sync2_q <= sync1_q;
      edge_q  <= sync2_q;
    end
  end

  assign ms_tick = sync2_q & ~edge_q;
  assign trip    = (state_q == S_RUN) && wdt_fault;

  always_comb begin
    state_d         = state_q;
    fault_latched_d = fault_latched_q;
    trip_count_d    = trip_count_q;
    retry_d         = retry_q;
    win_d           = win_q;
    hold_d          = hold_q;
    blank_d         = blank_q;
    trip_base       = trip_count_q;

    if (clear_status && (state_q != S_LOCK)) begin
      fault_latched_d = 1'b0;
      trip_count_d    = 8'd0;
      trip_base       = 8'd0;
    end

    case (state_q)
      S_RUN: begin
        if (trip) begin
          // A trip on the same cycle as a clear still counts, starting from zero
          trip_count_d    = (trip_base == 8'hFF) ? 8'hFF : trip_base + 8'd1;
          fault_latched_d = 1'b1;
          retry_d         = (retry_q == 8'hFF) ? 8'hFF : retry_q + 8'd1;
          win_d           = 16'd0;
          hold_d          = 16'd0;
          if ((MAX_RETRIES != 8'd0) && (retry_d >= MAX_RETRIES)) state_d = S_LOCK;
          else                                                   state_d = S_ASSERT;
        end else if (ms_tick) begin
          if (win_q == WIN_LAST) begin
            retry_d = 8'd0;
            win_d   = 16'd0;
          end else begin
            win_d = win_q + 16'd1;
          end
        end
      end
      S_ASSERT: begin
        if (ms_tick) begin
          if (hold_q == HOLD_LAST) begin
            state_d = S_BLANK;
            blank_d = 16'd0;
          end else begin
            hold_d = hold_q + 16'd1;
          end
        end
      end
      S_BLANK: begin
        if (BLANK_TIME == 16'd0) begin
          state_d = S_RUN;
        end else if (ms_tick) begin
          if (blank_q == BLANK_LAST) state_d = S_RUN;
          else                       blank_d = blank_q + 16'd1;
        end
      end
      default: begin
        if (clear_status) begin
          retry_d = 8'd0;
          blank_d = 16'd0;
          state_d = S_BLANK;
        end
      end
    endcase

    sys_reset_d = (state_d == S_ASSERT) || (state_d == S_LOCK);
    lockout_d   = (state_d == S_LOCK);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_RUN;
      sys_reset_q     <= 1'b0;
      lockout_q       <= 1'b0;
      fault_latched_q <= 1'b0;
      trip_count_q    <= 8'd0;
      retry_q         <= 8'd0;
      win_q           <= 16'd0;
      hold_q          <= 16'd0;
      blank_q         <= 16'd0;
    end else begin
      state_q         <= state_d;
      sys_reset_q     <= sys_reset_d;
      lockout_q       <= lockout_d;
      fault_latched_q <= fault_latched_d;
      trip_count_q    <= trip_count_d;
      retry_q         <= retry_d;
      win_q           <= win_d;
      hold_q          <= hold_d;
      blank_q         <= blank_d;
    end
  end

`ifdef RSTCTRL_TIMESTAMP_EN
  logic [15:0] ms_cnt_q, ms_cnt_d;
  logic [15:0] last_trip_q, last_trip_d;

  always_comb begin
    ms_cnt_d    = ms_tick ? ms_cnt_q + 16'd1 : ms_cnt_q;
    last_trip_d = trip ? ms_cnt_q : last_trip_q;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      ms_cnt_q    <= 16'd0;
      last_trip_q <= 16'd0;
    end else begin
      ms_cnt_q    <= ms_cnt_d;
      last_trip_q <= last_trip_d;
    end
  end

  assign last_trip_ms = last_trip_q;
`else
  assign last_trip_ms = 16'd0;
`endif

  assign sys_reset     = sys_reset_q;
  assign lockout       = lockout_q;
  assign fault_latched = fault_latched_q;
  assign trip_count    = trip_count_q;
  assign state         = state_q;

endmodule
